// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable first-word-fall-through read mode.
//
// Handshake: a push is taken on any rising edge where write_en=1 and the FIFO
// is not full; a pop is taken on any rising edge where read_en=1 and the FIFO
// is not empty. Rejected requests leave pointers and count untouched and only
// raise the matching sticky error flag.
//
// Threshold legality: 0 <= ALMOST_EMPTY_TH < ALMOST_FULL_TH <= 2**ADDR_WIDTH.
module sync_fifo_param #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_TH  = 14,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter bit FWFT            = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc, rd_acc;

    // Flags derive only from the registered count, so they move on the same
    // edge as the count itself.
    assign fifo_full    = (count_q == DEPTH_C);
    assign fifo_empty   = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign fill_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign wr_acc = write_en && !fifo_full;
    assign rd_acc = read_en && !fifo_empty;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
        else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
        // A new error event outranks a simultaneous clear.
        if (clear_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (write_en && fifo_full) ovf_d = 1'b1;
        if (read_en && fifo_empty) unf_d = 1'b1;
    end

    // Control state register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; never reset, stale words become unreachable instead.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT == 1'b0) begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            logic                  dv_q, dv_d;

            // Registered read: capture head word on a taken pop, else hold.
            always_comb begin
                dout_d = dout_q;
                dv_d   = rd_acc;
                if (rd_acc) dout_d = mem_q[rd_ptr_q];
            end

            // Read data register with single-cycle valid pulse.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dv_q   <= dv_d;
                end
            end

            assign data_out   = dout_q;
            assign data_valid = dv_q;
        end else begin : g_fwft
            // Head word is always presented; forced to zero while empty so the
            // post-reset output matches the standard mode.
            assign data_out   = fifo_empty ? '0 : mem_q[rd_ptr_q];
            assign data_valid = !fifo_empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param in both read modes.
module tb_sync_fifo_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // standard-mode instance signals
    logic       s_we, s_re, s_clr;
    logic [7:0] s_din, s_dout;
    logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0] s_cnt;

    // FWFT-mode instance signals
    logic       f_we, f_re, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_cnt;

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL_TH(14),
                      .ALMOST_EMPTY_TH(2), .FWFT(1'b0)) u_std (
        .clk(clk), .reset(reset), .write_en(s_we), .data_in(s_din),
        .read_en(s_re), .clear_err(s_clr), .data_out(s_dout),
        .data_valid(s_dv), .fifo_full(s_full), .fifo_empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .fill_count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL_TH(14),
                      .ALMOST_EMPTY_TH(2), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .write_en(f_we), .data_in(f_din),
        .read_en(f_re), .clear_err(f_clr), .data_out(f_dout),
        .data_valid(f_dv), .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .fill_count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf));

    // ---------------- scoreboard / counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       we, re, clr;
        logic [7:0] din;
        logic [7:0] dout;
        logic       dv;
        logic [4:0] cnt;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, re, clr, input logic [7:0] din,
                                input logic [7:0] dout, input logic dv,
                                input logic [4:0] cnt, input logic ovf, unf);
        vec_t v;
        v.we = we; v.re = re; v.clr = clr; v.din = din;
        v.dout = dout; v.dv = dv; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // Flags expected from a count, thresholds 14 / 2, depth 16.
    task automatic chk_std_flags(input string tag, input logic [4:0] cnt);
        chk({tag, " cnt"},   32'(s_cnt),   32'(cnt));
        chk({tag, " full"},  32'(s_full),  32'(cnt == 5'd16));
        chk({tag, " empty"}, 32'(s_empty), 32'(cnt == 5'd0));
        chk({tag, " af"},    32'(s_af),    32'(cnt >= 5'd14));
        chk({tag, " ae"},    32'(s_ae),    32'(cnt <= 5'd2));
    endtask

    task automatic s_idle();
        s_we = 1'b0; s_re = 1'b0; s_clr = 1'b0; s_din = 8'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        s_idle();
        f_we = 1'b0; f_re = 1'b0; f_clr = 1'b0; f_din = 8'h00;
        tick(); tick();

        // reset state, both modes
        chk_std_flags("rst", 5'd0);
        chk("rst dout", 32'(s_dout), 32'h0);
        chk("rst dv",   32'(s_dv),   32'h0);
        chk("rst ovf",  32'(s_ovf),  32'h0);
        chk("rst unf",  32'(s_unf),  32'h0);
        chk("rst f_dout", 32'(f_dout), 32'h0);
        chk("rst f_dv",   32'(f_dv),   32'h0);
        chk("rst f_cnt",  32'(f_cnt),  32'h0);
        reset = 1'b0;

        // vector table: fill, overflow, drain, underflow, clear interactions
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 0, 0, 8'(i), 8'h00, 0, 5'(i + 1), 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'hAA, 8'h00, 0, 5'd16, 1, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 0, 8'h00, 8'(i), 1, 5'(15 - i), 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h0F, 0, 5'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h0F, 0, 5'd0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h00, 8'h0F, 0, 5'd0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h0F, 0, 5'd0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            s_we = vecs[i].we; s_re = vecs[i].re; s_clr = vecs[i].clr;
            s_din = vecs[i].din;
            tick();
            chk_std_flags($sformatf("v%0d", i), vecs[i].cnt);
            chk($sformatf("v%0d dout", i), 32'(s_dout), 32'(vecs[i].dout));
            chk($sformatf("v%0d dv", i),   32'(s_dv),   32'(vecs[i].dv));
            chk($sformatf("v%0d ovf", i),  32'(s_ovf),  32'(vecs[i].ovf));
            chk($sformatf("v%0d unf", i),  32'(s_unf),  32'(vecs[i].unf));
        end
        s_idle();

        // prime 8 words, then 40 simultaneous write/read cycles, then drain
        for (int k = 0; k < 8; k++) begin
            s_we = 1'b1; s_din = 8'(8'h80 + k);
            exp_q.push_back(s_din);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            logic [7:0] e;
            s_we = 1'b1; s_re = 1'b1; s_din = 8'(8'hC0 + k);
            exp_q.push_back(s_din);
            e = exp_q.pop_front();
            tick();
            chk($sformatf("ss%0d cnt", k),  32'(s_cnt),  32'd8);
            chk($sformatf("ss%0d dv", k),   32'(s_dv),   32'h1);
            chk($sformatf("ss%0d dout", k), 32'(s_dout), 32'(e));
        end
        s_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            s_re = 1'b1;
            e = exp_q.pop_front();
            tick();
            chk($sformatf("dr%0d dout", k), 32'(s_dout), 32'(e));
            chk($sformatf("dr%0d cnt", k),  32'(s_cnt),  32'(7 - k));
        end
        s_idle();
        tick();
        chk("drain dv", 32'(s_dv), 32'h0);
        chk_std_flags("drain", 5'd0);

        // reset with 5 stored words and a read in flight
        for (int k = 0; k < 5; k++) begin
            s_we = 1'b1; s_din = 8'(8'h50 + k);
            tick();
        end
        s_we = 1'b0; s_re = 1'b1;
        tick();
        chk("pre-rst dv",   32'(s_dv),   32'h1);
        chk("pre-rst dout", 32'(s_dout), 32'h50);
        s_we = 1'b1; s_din = 8'hEE; reset = 1'b1;
        tick();
        reset = 1'b0;
        s_idle();
        chk_std_flags("mrst", 5'd0);
        chk("mrst dout", 32'(s_dout), 32'h0);
        chk("mrst dv",   32'(s_dv),   32'h0);
        chk("mrst ovf",  32'(s_ovf),  32'h0);
        chk("mrst unf",  32'(s_unf),  32'h0);
        s_we = 1'b1; s_din = 8'h77;
        tick();
        chk("post-rst cnt", 32'(s_cnt), 32'd1);
        s_we = 1'b0; s_re = 1'b1;
        tick();
        s_idle();
        chk("post-rst dout", 32'(s_dout), 32'h77);
        chk("post-rst dv",   32'(s_dv),   32'h1);
        chk("post-rst cnt2", 32'(s_cnt),  32'd0);

        // FWFT sequence
        f_we = 1'b1; f_din = 8'h5C;
        tick();
        f_we = 1'b0;
        chk("fw1 dout", 32'(f_dout), 32'h5C);
        chk("fw1 dv",   32'(f_dv),   32'h1);
        chk("fw1 cnt",  32'(f_cnt),  32'd1);
        tick();
        chk("fw2 dout", 32'(f_dout), 32'h5C);
        f_we = 1'b1; f_din = 8'h3E;
        tick();
        f_we = 1'b0;
        chk("fw3 dout", 32'(f_dout), 32'h5C);
        chk("fw3 cnt",  32'(f_cnt),  32'd2);
        f_re = 1'b1;
        tick();
        chk("fw4 dout", 32'(f_dout), 32'h3E);
        chk("fw4 dv",   32'(f_dv),   32'h1);
        chk("fw4 cnt",  32'(f_cnt),  32'd1);
        tick();
        chk("fw5 dv",    32'(f_dv),    32'h0);
        chk("fw5 empty", 32'(f_empty), 32'h1);
        chk("fw5 unf",   32'(f_unf),   32'h0);
        tick();
        f_re = 1'b0;
        chk("fw6 unf", 32'(f_unf), 32'h1);
        chk("fw6 cnt", 32'(f_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
